// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//   Sliding KSIZE x KSIZE window generator for a raster-order pixel stream.
//   KSIZE-1 line memories hold the previous image rows; a register window
//   shifts by one column per accepted pixel. A completed window is presented
//   on dout with out_valid and held until the consumer accepts it.
//
// Optional feature (compile-time macro): CONV_WINDOW_LAST_EN
//   Adds out_last, high with out_valid on the final window of each frame.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   clear      : synchronous frame restart (drops a pixel offered that cycle)
//   din        : pixel word, raster order
//   in_valid   : din valid
//   in_ready   : pixel accepted when in_valid && in_ready
//   dout       : window, word r*KSIZE+c at [WORDWIDTH*(idx+1)-1 : WORDWIDTH*idx]
//                r=0 oldest row, c=0 oldest column
//   out_valid  : dout valid
//   out_ready  : consumer accepts the window when out_valid && out_ready
//   out_last   : (CONV_WINDOW_LAST_EN only) final window of the frame
// -----------------------------------------------------------------------------
module conv_window_gen #(
  parameter int WORDWIDTH   = 32,
  parameter int FIG_WIDTH   = 28,
  parameter int FIG_HEIGHT  = 28,
  parameter int KSIZE       = 5,
  parameter int STRIDE      = 1,
  parameter int FIG_ADDRLEN = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic [WORDWIDTH-1:0]               din,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [WORDWIDTH*KSIZE*KSIZE-1:0]   dout,
  output logic                               out_valid,
  input  logic                               out_ready
`ifdef CONV_WINDOW_LAST_EN
  ,
  output logic                               out_last
`endif
);

  localparam int ROW_W = (FIG_HEIGHT > 1) ? $clog2(FIG_HEIGHT) : 1;

  logic [FIG_ADDRLEN-1:0] col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   out_valid_q, out_valid_d;
  logic                   accept;
  logic                   complete;
  int                     row_off;
  int                     col_off;

  // Window registers: win_q[r][c], r=0 oldest row, c=0 oldest column.
  logic [WORDWIDTH-1:0] win_q   [KSIZE][KSIZE];
  // line_q[0] holds row-1, line_q[KSIZE-2] holds row-KSIZE+1.
  logic [WORDWIDTH-1:0] line_q  [KSIZE-1][FIG_WIDTH];
  // Column entering the window on an accepted pixel, oldest row first.
  logic [WORDWIDTH-1:0] new_col [KSIZE];

  // No skid buffer: a pending window blocks input; clear and reset also block.
  assign in_ready  = rst_n & ~clear & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;

  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      new_col[r] = '0;
    end
    new_col[KSIZE-1] = din;
    for (int k = 0; k < KSIZE-1; k++) begin
      new_col[KSIZE-2-k] = line_q[k][col_q];
    end
  end

  // A window completes only when every column and row it covers belongs to
  // the current row/frame, which also keeps stale line-memory data out.
  always_comb begin
    row_off  = int'(row_q) - (KSIZE-1);
    col_off  = int'(col_q) - (KSIZE-1);
    complete = (row_off >= 0) && (col_off >= 0) &&
               ((row_off % STRIDE) == 0) && ((col_off % STRIDE) == 0);
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      col_d       = '0;
      row_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (accept) begin
        if (col_q == FIG_ADDRLEN'(FIG_WIDTH-1)) begin
          col_d = '0;
          row_d = (row_q == ROW_W'(FIG_HEIGHT-1)) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      if (accept && complete) begin
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE-1; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
          win_q[r][KSIZE-1] <= new_col[r];
        end
      end
    end
  end

  // Line memories are plain storage with no reset; each accepted pixel
  // pushes its column one row deeper.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_q[0][col_q] <= din;
      for (int k = 1; k < KSIZE-1; k++) begin
        line_q[k][col_q] <= line_q[k-1][col_q];
      end
    end
  end

  for (genvar gr = 0; gr < KSIZE; gr++) begin : g_row
    for (genvar gc = 0; gc < KSIZE; gc++) begin : g_col
      assign dout[WORDWIDTH*(gr*KSIZE+gc) +: WORDWIDTH] = win_q[gr][gc];
    end
  end

`ifdef CONV_WINDOW_LAST_EN
  // Position of the last stride-aligned window origin's bottom-right pixel.
  localparam int LAST_ROW = (KSIZE-1) + ((FIG_HEIGHT-KSIZE)/STRIDE)*STRIDE;
  localparam int LAST_COL = (KSIZE-1) + ((FIG_WIDTH-KSIZE)/STRIDE)*STRIDE;

  logic out_last_q, out_last_d;
  logic is_last;

  assign is_last  = (int'(row_q) == LAST_ROW) && (int'(col_q) == LAST_COL);
  assign out_last = out_last_q;

  always_comb begin
    out_last_d = out_last_q;
    if (clear) begin
      out_last_d = 1'b0;
    end else if (accept && complete) begin
      out_last_d = is_last;
    end else if (out_ready) begin
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_last_q <= 1'b0;
    end else begin
      out_last_q <= out_last_d;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;
  localparam int W  = 8;
  localparam int FW = 6;
  localparam int FH = 6;
  localparam int K  = 3;
  localparam int DW = W*K*K;

  typedef struct {
    logic [DW-1:0] win;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic [W-1:0]  din = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] dout;

  logic          in_valid2;
  logic          in_ready2;
  logic          out_valid2;
  logic [DW-1:0] dout2;
  logic          out_ready2 = 1'b1;

`ifdef CONV_WINDOW_LAST_EN
  logic out_last;
  logic out_last2;
  int   last_cnt;
  int   last_at [4];
`endif

  // Stride-2 instance sees exactly the pixels the stride-1 instance accepts.
  assign in_valid2 = in_valid & in_ready;

  always #5 clk = ~clk;

  conv_window_gen #(
    .WORDWIDTH(W), .FIG_WIDTH(FW), .FIG_HEIGHT(FH), .KSIZE(K), .STRIDE(1), .FIG_ADDRLEN(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .din(din), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .out_valid(out_valid), .out_ready(out_ready)
`ifdef CONV_WINDOW_LAST_EN
    , .out_last(out_last)
`endif
  );

  conv_window_gen #(
    .WORDWIDTH(W), .FIG_WIDTH(FW), .FIG_HEIGHT(FH), .KSIZE(K), .STRIDE(2), .FIG_ADDRLEN(3)
  ) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .din(din), .in_valid(in_valid2),
    .in_ready(in_ready2), .dout(dout2), .out_valid(out_valid2), .out_ready(out_ready2)
`ifdef CONV_WINDOW_LAST_EN
    , .out_last(out_last2)
`endif
  );

  int   vectors = 0;
  int   fails = 0;
  int   mrow = 0;
  int   mcol = 0;
  logic [W-1:0] img [FH][FW];
  exp_t q1 [$];
  exp_t q2 [$];
  exp_t e1;
  exp_t e2;
  int   win_cnt = 0;
  int   win_cnt2 = 0;
  int   last_idx8 = 0;
  int   idx8_log [64];
  int   s2_idx8 [8];

  // Reference model: records the accepted pixel and queues any window it completes.
  task automatic model_accept(input logic [W-1:0] v);
    exp_t e;
    img[mrow][mcol] = v;
    if (mrow >= K-1 && mcol >= K-1) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          e.win[W*(r*K+c) +: W] = img[mrow-K+1+r][mcol-K+1+c];
      e.last = (mrow == FH-1 && mcol == FW-1);
      q1.push_back(e);
      if (((mrow-K+1) % 2 == 0) && ((mcol-K+1) % 2 == 0)) begin
        e.last = (mrow == 4 && mcol == 4);
        q2.push_back(e);
      end
    end
    if (mcol == FW-1) begin
      mcol = 0;
      mrow = (mrow == FH-1) ? 0 : mrow + 1;
    end else begin
      mcol = mcol + 1;
    end
  endtask

  task automatic model_restart();
    mrow = 0;
    mcol = 0;
    q1.delete();
    q2.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL win_unexpected: got %h, required no window", dout);
      end else begin
        e1 = q1.pop_front();
        if (dout !== e1.win) begin
          fails++;
          $display("FAIL win_data: got %h, required %h", dout, e1.win);
        end
`ifdef CONV_WINDOW_LAST_EN
        vectors++;
        if (out_last !== e1.last) begin
          fails++;
          $display("FAIL win_last: got %b, required %b", out_last, e1.last);
        end
        if (out_last === 1'b1) begin
          if (last_cnt < 4) last_at[last_cnt] = win_cnt + 1;
          last_cnt++;
        end
`endif
      end
      if (win_cnt < 64) idx8_log[win_cnt] = int'(dout[DW-1 -: W]);
      last_idx8 = int'(dout[DW-1 -: W]);
      win_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid2 && out_ready2) begin
      vectors++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL s2_unexpected: got %h, required no window", dout2);
      end else begin
        e2 = q2.pop_front();
        if (dout2 !== e2.win) begin
          fails++;
          $display("FAIL s2_data: got %h, required %h", dout2, e2.win);
        end
`ifdef CONV_WINDOW_LAST_EN
        vectors++;
        if (out_last2 !== e2.last) begin
          fails++;
          $display("FAIL s2_last: got %b, required %b", out_last2, e2.last);
        end
`endif
      end
      if (win_cnt2 < 8) s2_idx8[win_cnt2] = int'(dout2[DW-1 -: W]);
      win_cnt2++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one pixel until accepted; returns 1 time unit after the accepting edge.
  task automatic send_pixel(input int v);
    int guard;
    guard = 0;
    din = W'(v);
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        model_accept(W'(v));
        tick();
        in_valid = 1'b0;
        break;
      end
      tick();
      guard++;
      if (guard > 50) begin
        vectors++;
        fails++;
        $display("FAIL accept_timeout: pixel %0d not accepted, required acceptance", v);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_frame();
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++)
        send_pixel(r*FW + c);
  endtask

  task automatic check_frame_end(input string name, input int cnt_req);
    repeat (4) tick();
    vectors++;
    if (win_cnt !== cnt_req) begin
      fails++;
      $display("FAIL %s_count: got %0d, required %0d", name, win_cnt, cnt_req);
    end
    vectors++;
    if (last_idx8 !== 35) begin
      fails++;
      $display("FAIL %s_last_idx8: got %0d, required 35", name, last_idx8);
    end
    vectors++;
    if (q1.size() !== 0) begin
      fails++;
      $display("FAIL %s_pending: got %0d windows outstanding, required 0", name, q1.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || dout !== '0) begin
      fails++;
      $display("FAIL %s_dut1: got vld=%b rdy=%b dout=%h, required 0 0 0", name, out_valid, in_ready, dout);
    end
    vectors++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b0 || dout2 !== '0) begin
      fails++;
      $display("FAIL %s_dut2: got vld=%b rdy=%b dout=%h, required 0 0 0", name, out_valid2, in_ready2, dout2);
    end
`ifdef CONV_WINDOW_LAST_EN
    vectors++;
    if (out_last !== 1'b0 || out_last2 !== 1'b0) begin
      fails++;
      $display("FAIL %s_last: got %b %b, required 0 0", name, out_last, out_last2);
    end
`endif
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_after: got %b, required 1", in_ready);
    end
    tick();
  endtask

  task automatic test_stream();
    win_cnt = 0;
    for (int p = 0; p < FW*FH; p++) begin
      send_pixel(p);
      if (p == 13) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          fails++;
          $display("FAIL stream_early_valid: got %b, required 0", out_valid);
        end
      end
      if (p == 14) begin
        vectors++;
        if (out_valid !== 1'b1) begin
          fails++;
          $display("FAIL stream_first_valid: got %b, required 1", out_valid);
        end
        vectors++;
        if (dout[7:0] !== 8'd0 || dout[39:32] !== 8'd7 || dout[71:64] !== 8'd14) begin
          fails++;
          $display("FAIL stream_first_win: got idx0=%0d idx4=%0d idx8=%0d, required 0 7 14",
                   dout[7:0], dout[39:32], dout[71:64]);
        end
      end
    end
    check_frame_end("stream", 16);
  endtask

  task automatic test_stride();
    int req [4];
    req = '{14, 16, 26, 28};
    win_cnt = 0;
    win_cnt2 = 0;
    send_frame();
    check_frame_end("stride_ref", 16);
    vectors++;
    if (win_cnt2 !== 4) begin
      fails++;
      $display("FAIL stride_count: got %0d, required 4", win_cnt2);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (s2_idx8[i] !== req[i]) begin
        fails++;
        $display("FAIL stride_idx8_%0d: got %0d, required %0d", i, s2_idx8[i], req[i]);
      end
    end
    vectors++;
    if (q2.size() !== 0) begin
      fails++;
      $display("FAIL stride_pending: got %0d, required 0", q2.size());
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] hold;
    win_cnt = 0;
    for (int p = 0; p <= 14; p++) send_pixel(p);
    out_ready = 1'b0;
    din = 8'd15;
    in_valid = 1'b1;
    hold = dout;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dout !== hold) begin
        fails++;
        $display("FAIL stall_hold_%0d: got vld=%b rdy=%b dout=%h, required 1 0 %h",
                 i, out_valid, in_ready, dout, hold);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int p = 15; p < FW*FH; p++) send_pixel(p);
    check_frame_end("stall", 16);
  endtask

  task automatic test_reset_midframe();
    for (int p = 0; p <= 20; p++) send_pixel(p);
    rst_n = 1'b0;
    model_restart();
    @(negedge clk);
    check_reset_outputs("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    win_cnt = 0;
    send_frame();
    check_frame_end("midreset", 16);
  endtask

  task automatic test_clear();
    for (int p = 0; p < 10; p++) send_pixel(p);
    din = 8'd10;
    in_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL clear_ready: got %b, required 0", in_ready);
    end
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    model_restart();
    vectors++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_valid: got %b, required 0", out_valid);
    end
    win_cnt = 0;
    send_frame();
    check_frame_end("clear", 16);
  endtask

  task automatic test_back_to_back();
    win_cnt = 0;
`ifdef CONV_WINDOW_LAST_EN
    last_cnt = 0;
`endif
    send_frame();
    send_frame();
    check_frame_end("b2b", 32);
    vectors++;
    if (idx8_log[15] !== 35 || idx8_log[31] !== 35) begin
      fails++;
      $display("FAIL b2b_idx8: got %0d %0d, required 35 35", idx8_log[15], idx8_log[31]);
    end
`ifdef CONV_WINDOW_LAST_EN
    vectors++;
    if (last_cnt !== 2 || last_at[0] !== 16 || last_at[1] !== 32) begin
      fails++;
      $display("FAIL b2b_last_pos: got cnt=%0d at %0d,%0d, required 2 at 16,32",
               last_cnt, last_at[0], last_at[1]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stride();
    test_stall();
    test_reset_midframe();
    test_clear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
